// File: rtl/pc_next_seq.sv
// Next-address sequencer for the program counter: SEQ/JMP/branch/CALL/RET with run/halt control.
// Optional return stack, CALL/RET and ovf/unf flags are built when PCSEQ_RETSTACK_EN is defined.
module pc_next_seq #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            pc,
  input  logic                     valid,
  input  logic [2:0]               op,
  input  logic [AW-1:0]            target,
  input  logic                     zero,
  output logic [AW-1:0]            next,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     ovf,
  output logic                     unf
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = $clog2(DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HOLD = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [AW-1:0] pc_inc;

  assign pc_inc = pc + 1'b1;

`ifdef PCSEQ_RETSTACK_EN
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [SPW-1:0] sp_reg, sp_next;
  logic           ovf_reg, ovf_next;
  logic           unf_reg, unf_next;
  logic           push;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;
  logic [AW-1:0]  stack_word [DEPTH];
  logic [AW-1:0]  stack_top;

  assign wr_idx    = sp_reg[IW-1:0];
  assign top_idx   = IW'(sp_reg - 1'b1);
  assign stack_top = stack_word[top_idx];

  // Each entry is its own register; contents are don't-care after reset, so no reset term.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_idx == IW'(gi))) begin
          entry_reg <= pc_inc;
        end
      end
      assign stack_word[gi] = entry_reg;
    end
  endgenerate
`endif

  always_comb begin
    next       = pc;
    state_next = state_reg;
`ifdef PCSEQ_RETSTACK_EN
    sp_next  = sp_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    push     = 1'b0;
`endif
    if (rst) begin
      next = '0;
    end else if ((state_reg == ST_RUN) && valid) begin
      case (op)
        OP_SEQ:  next = pc_inc;
        OP_JMP:  next = target;
        OP_BZ:   next = zero ? target : pc_inc;
        OP_BNZ:  next = zero ? pc_inc : target;
`ifdef PCSEQ_RETSTACK_EN
        OP_CALL: begin
          if (sp_reg == SP_FULL) begin
            ovf_next   = 1'b1;
            state_next = ST_HALT;
          end else begin
            next    = target;
            push    = 1'b1;
            sp_next = sp_reg + 1'b1;
          end
        end
        OP_RET: begin
          if (sp_reg == '0) begin
            unf_next   = 1'b1;
            state_next = ST_HALT;
          end else begin
            next    = stack_top;
            sp_next = sp_reg - 1'b1;
          end
        end
`else
        OP_CALL: next = target;
        OP_RET:  next = pc_inc;
`endif
        OP_HOLD: next = pc;
        OP_HALT: state_next = ST_HALT;
        default: next = pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign halted = (state_reg == ST_HALT);

`ifdef PCSEQ_RETSTACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign sp  = sp_reg;
  assign ovf = ovf_reg;
  assign unf = unf_reg;
`else
  assign sp  = '0;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
// Directed scoreboard bench for pc_next_seq; covers the stack feature when PCSEQ_RETSTACK_EN is defined.
module tb_pc_next_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pc = 4'h0;
  logic       valid = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] target = 4'h0;
  logic       zero = 1'b0;
  logic [3:0] next;
  logic       halted;
  logic [2:0] sp;
  logic       ovf;
  logic       unf;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BZ = 3'b010, BNZ = 3'b011;
  localparam logic [2:0] CALL = 3'b100, RET = 3'b101, HOLD = 3'b110, HLT = 3'b111;

  pc_next_seq #(.AW(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .valid(valid), .op(op), .target(target),
    .zero(zero), .next(next), .halted(halted), .sp(sp), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("chk %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one op at the falling edge, queue the expected next, compare once it settles.
  task automatic drive(input string tag, input logic v, input logic [2:0] o, input logic [3:0] p,
                       input logic [3:0] t, input logic z, input logic [3:0] e);
    @(negedge clk);
    valid = v; op = o; pc = p; target = t; zero = z;
    exp_q.push_back(e);
    #1;
    check(tag, 8'(next), 8'(exp_q.pop_front()));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_next", 8'(next), 8'h00);
    check("rst_sp", 8'(sp), 8'h00);
    check("rst_halted", 8'(halted), 8'h00);
    check("rst_ovf", 8'(ovf), 8'h00);
    check("rst_unf", 8'(unf), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    drive("seq_e", 1'b1, SEQ, 4'hE, 4'h0, 1'b0, 4'hF);
    drive("seq_wrap", 1'b1, SEQ, 4'hF, 4'h0, 1'b0, 4'h0);
    after_edge();
    check("run_halted", 8'(halted), 8'h00);

    drive("bz_taken", 1'b1, BZ, 4'h3, 4'h9, 1'b1, 4'h9);
    drive("bz_not", 1'b1, BZ, 4'h3, 4'h9, 1'b0, 4'h4);
    drive("bnz_taken", 1'b1, BNZ, 4'h3, 4'h9, 1'b0, 4'h9);
    drive("bnz_not", 1'b1, BNZ, 4'h3, 4'h9, 1'b1, 4'h4);
    drive("jmp", 1'b1, JMP, 4'h3, 4'h9, 1'b0, 4'h9);
    drive("hold", 1'b1, HOLD, 4'h3, 4'h9, 1'b0, 4'h3);
    drive("invalid", 1'b0, JMP, 4'h3, 4'h9, 1'b0, 4'h3);
    after_edge();
    check("invalid_sp", 8'(sp), 8'h00);

`ifdef PCSEQ_RETSTACK_EN
    drive("call1", 1'b1, CALL, 4'h2, 4'h8, 1'b0, 4'h8);
    after_edge();
    check("call1_sp", 8'(sp), 8'h01);
    drive("call2", 1'b1, CALL, 4'h9, 4'hC, 1'b0, 4'hC);
    after_edge();
    check("call2_sp", 8'(sp), 8'h02);
    drive("ret1", 1'b1, RET, 4'hC, 4'h0, 1'b0, 4'hA);
    after_edge();
    check("ret1_sp", 8'(sp), 8'h01);
    drive("ret2", 1'b1, RET, 4'hB, 4'h0, 1'b0, 4'h3);
    after_edge();
    check("ret2_sp", 8'(sp), 8'h00);

    drive("ovf_c1", 1'b1, CALL, 4'h1, 4'h2, 1'b0, 4'h2);
    drive("ovf_c2", 1'b1, CALL, 4'h2, 4'h3, 1'b0, 4'h3);
    drive("ovf_c3", 1'b1, CALL, 4'h3, 4'h4, 1'b0, 4'h4);
    drive("ovf_c4", 1'b1, CALL, 4'hF, 4'h5, 1'b0, 4'h5);
    after_edge();
    check("full_sp", 8'(sp), 8'h04);
    check("full_ovf", 8'(ovf), 8'h00);
    drive("ovf_c5", 1'b1, CALL, 4'h5, 4'h6, 1'b0, 4'h5);
    after_edge();
    check("ovf_flag", 8'(ovf), 8'h01);
    check("ovf_halted", 8'(halted), 8'h01);
    check("ovf_sp", 8'(sp), 8'h04);
    drive("ovf_jmp", 1'b1, JMP, 4'h6, 4'h5, 1'b0, 4'h6);

    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    check("clr_ovf", 8'(ovf), 8'h00);
    check("clr_sp", 8'(sp), 8'h00);

    drive("unf_ret", 1'b1, RET, 4'h4, 4'h0, 1'b0, 4'h4);
    after_edge();
    check("unf_flag", 8'(unf), 8'h01);
    check("unf_halted", 8'(halted), 8'h01);
    check("unf_sp", 8'(sp), 8'h00);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_next", 8'(next), 8'h00);
    check("mid_rst_halt", 8'(halted), 8'h00);
    check("mid_rst_unf", 8'(unf), 8'h00);
    check("mid_rst_sp", 8'(sp), 8'h00);
    #1 rst = 1'b0;
    drive("post_rst_seq", 1'b1, SEQ, 4'h4, 4'h0, 1'b0, 4'h5);
    // Return address wraps modulo 16 when calling from the last address.
    drive("call_wrap", 1'b1, CALL, 4'hF, 4'h8, 1'b0, 4'h8);
    drive("ret_wrap", 1'b1, RET, 4'h8, 4'h0, 1'b0, 4'h0);
    after_edge();
    check("ret_wrap_sp", 8'(sp), 8'h00);
`else
    drive("call_as_jmp", 1'b1, CALL, 4'h2, 4'h7, 1'b0, 4'h7);
    after_edge();
    check("nostk_sp", 8'(sp), 8'h00);
    check("nostk_ovf", 8'(ovf), 8'h00);
    drive("ret_as_seq", 1'b1, RET, 4'h7, 4'h0, 1'b0, 4'h8);
    after_edge();
    check("nostk_unf", 8'(unf), 8'h00);
    check("nostk_halted", 8'(halted), 8'h00);
    drive("ret_empty", 1'b1, RET, 4'hF, 4'h0, 1'b0, 4'h0);
    after_edge();
    check("nostk_unf2", 8'(unf), 8'h00);
    check("nostk_halt2", 8'(halted), 8'h00);
`endif

    drive("halt_op", 1'b1, HLT, 4'h6, 4'h2, 1'b0, 4'h6);
    after_edge();
    check("halt_state", 8'(halted), 8'h01);
    drive("halted_seq", 1'b1, SEQ, 4'h6, 4'h2, 1'b0, 4'h6);
    drive("halted_jmp", 1'b1, JMP, 4'h6, 4'h5, 1'b0, 4'h6);
    after_edge();
    check("still_halted", 8'(halted), 8'h01);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("halt_rst_next", 8'(next), 8'h00);
    check("halt_rst_state", 8'(halted), 8'h00);
    #1 rst = 1'b0;
    drive("resume_seq", 1'b1, SEQ, 4'h6, 4'h0, 1'b0, 4'h7);
    after_edge();
    check("resume_halted", 8'(halted), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_seq.md
# pc_next_seq

Next-address sequencer driving the program counter's `next` input. Each cycle it takes the current `pc` and a decoded control-flow op, and combinationally produces the address to load at the following clock edge. It supports sequential, jump, conditional branch, call and return. A small hardware return stack holds return addresses, and a two-state run/halt machine freezes the program counter on HALT or on a stack fault.

## Interface
- `AW`, default 4, address width; must match the program counter width.
- `DEPTH`, default 4, number of return-stack entries; must be a power of two, ≥2.
- `clk`  in  1  rising-edge clock shared with the program counter.
- `rst`  in  1  reset: asynchronous and active-high.
- `pc`  in  AW  current program counter value.
- `valid`  in  1  `op` is meaningful this cycle; 0 means hold.
- `op`  in  3  encoding: 000 SEQ, 001 JMP, 010 BZ, 011 BNZ, 100 CALL, 101 RET, 110 HOLD, 111 HALT.
- `target`  in  AW  jump, branch or call destination.
- `zero`  in  1  ALU zero flag for BZ/BNZ.
- `next`  out  AW  combinational next address, wired to the program counter `next`.
- `halted`  out  1  registered; 1 in HALT state.
- `sp`  out  clog2(DEPTH)+1  registered return-stack occupancy, 0..DEPTH.
- `ovf`  out  1  sticky; set when a CALL is made with the stack full.
- `unf`  out  1  sticky; set when a RET is made with the stack empty.

## Operation
- States are RUN and HALT. Reset enters RUN.
- In HALT, `next = pc` and all ops are ignored. The only exit is `rst`.
- `next` in RUN when `valid=1`:
  - SEQ: `pc+1`.
  - JMP: `target`.
  - BZ: `target` if `zero`, else `pc+1`.
  - BNZ: `target` if `!zero`, else `pc+1`.
  - CALL: `target`.
  - RET: top of stack.
  - HOLD: `pc`.
  - HALT: `pc`.
- In RUN with `valid=0`, `next = pc`. No state, stack or flag changes.
- All additions are modulo 2^AW: `pc` = all-ones gives `pc+1` = 0. This applies to both SEQ and the CALL return address.
- CALL with `sp<DEPTH`: push `pc+1` and increment `sp`.
- CALL with `sp==DEPTH`: no push, `next = pc`, set `ovf`, go to HALT.
- RET with `sp>0`: `next = stack[sp-1]`, decrement `sp`.
- RET with `sp==0`: `next = pc`, set `unf`, go to HALT.
- HALT op: go to HALT. `next = pc` in the same cycle.
- `ovf`/`unf` stay set until `rst`. Popped entries are not cleared.

## Timing
- `next` is purely combinational from `pc`, `op`, `valid`, `target`, `zero`, state and stack top. It settles in the same cycle.
- The program counter loads `next` on the same rising edge on which this block updates its stack, `sp`, state and flags.
- `halted`, `ovf` and `unf` rise one edge after the triggering op. `next` already equals `pc` in the triggering cycle.
- Asynchronous reset, effective immediately when `rst` rises, including mid-CALL or mid-RET:
  - `sp=0`, `halted=0`, `ovf=0`, `unf=0`, state RUN.
  - Stack contents become don't-care.
  - `next` is forced to 0 while `rst` is high.
- First op is accepted on the first rising edge after `rst` deasserts.

## Configuration
- `PCSEQ_RETSTACK_EN` defined: return stack, CALL/RET behaviour, `ovf`/`unf` as described above.
- Not defined: no stack storage is built.
  - CALL behaves as JMP. RET behaves as SEQ.
  - `sp`, `ovf` and `unf` are tied to 0.
  - HALT is reachable only by the HALT op.

## Test plan
- Reset and SEQ wrap: assert `rst` → `next=0`, `sp=0`, all flags 0. Release, then drive SEQ with `pc=4'hE` then `4'hF` → `next=4'hF` then `4'h0`.
- Branches: `pc=3`, `target=9`.
  - BZ with `zero=1` → `next=9`.
  - BZ with `zero=0` → `next=4`.
  - BNZ with `zero=0` → `next=9`.
  - `valid=0` → `next=3`, `sp` unchanged.
- Call/return nesting:
  - CALL at `pc=2` (`target=8`) → `next=8`, then `sp=1`.
  - CALL at `pc=9` (`target=C`) → `next=C`, then `sp=2`.
  - RET → `next=A`.
  - RET → `next=3`, `sp=0`.
- Overflow: with `DEPTH=4`, five CALLs → the fifth gives `next=pc`. On the next edge `ovf=1`, `halted=1`, `sp=4`. Subsequent JMP to 5 → `next=pc`.
- Underflow and reset mid-operation:
  - RET with `sp=0` → `unf=1`, `halted=1`.
  - Pulse `rst` asynchronously between edges → `halted`, `unf` and `sp` clear immediately.
  - SEQ after release → `next=pc+1`.
- Without `PCSEQ_RETSTACK_EN`: CALL at `pc=2`, `target=7` → `next=7`, `sp=0`. RET at `pc=7` → `next=8`. `ovf` and `unf` stay 0.
